uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single `uart_tx_module` transmitter among several byte producers, e.g. the boot-message printer, the CPU `OUT` path and future debug sources. It sits between the requesters and the UART transmitter. It owns `tx_data` and `tx_start`, sequences one UART frame at a time against `tx_busy`, and holds the grant for the whole of a multi-byte message so that strings are not interleaved.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/rr_pick.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 116 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU-side UART path: byte width, UART bit timing
// and the transmit arbiter state encoding.
package cpu_pkg;

    localparam int BYTE_W     = 8;
    localparam int BIT_PERIOD = 1250;

    localparam logic [1:0] ARB_IDLE      = 2'd0;
    localparam logic [1:0] ARB_LAUNCH    = 2'd1;
    localparam logic [1:0] ARB_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ARB_WAIT_DONE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE      = ARB_IDLE,
        S_LAUNCH    = ARB_LAUNCH,
        S_WAIT_BUSY = ARB_WAIT_BUSY,
        S_WAIT_DONE = ARB_WAIT_DONE
    } arb_state_e;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set bit of valid at or
// above ptr, searching upward with wrap.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int                 k;
        logic [IDX_W-1:0]   k_idx;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        k      = 0;
        k_idx  = '0;
        for (int off = 0; off < N; off++) begin
            k = int'(ptr) + off;
            if (k >= N) k = k - N;
            k_idx = k[IDX_W-1:0];
            if (!any && valid[k_idx]) begin
                any           = 1'b1;
                onehot[k_idx] = 1'b1;
                idx           = k_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte producers; round-robin between
// messages, grant held for the whole of a multi-byte message.
//
// state       | meaning
// S_IDLE      | pick a requester (owner only when locked), latch its byte
// S_LAUNCH    | one-cycle tx_start pulse
// S_WAIT_BUSY | wait for the transmitter to report busy
// S_WAIT_DONE | wait for the frame to finish
module uart_tx_arbiter
    import cpu_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [BYTE_W*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    output logic [BYTE_W-1:0]         tx_data,
    output logic                      tx_start,
    input  logic                      tx_busy,
    output logic [N_REQ-1:0]          grant,
    output logic                      locked,
    output logic [CNT_W-1:0]          tx_count
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_e         state, state_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   pick_idx;
    logic [N_REQ-1:0]   eligible;
    logic [N_REQ-1:0]   pick_onehot;
    logic               pick_any;
    logic               accept;
    logic               accept_last;
    logic [BYTE_W-1:0]  pick_byte;

    // While locked, grant is the owner's one-hot, so masking leaves only the owner.
    assign eligible = locked ? (req_valid & grant) : req_valid;

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .valid  (eligible),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        pick_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_onehot[i]) pick_byte = pick_byte | req_data[i*BYTE_W +: BYTE_W];
        end
        accept_last = |(req_last & pick_onehot);
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        tx_start  = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (rst_n && !tx_busy && pick_any) begin
                    req_ready = pick_onehot;
                    accept    = 1'b1;
                    state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                tx_start  = 1'b1;
                state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (!tx_busy) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            tx_data  <= '0;
            grant    <= '0;
            locked   <= 1'b0;
            rr_ptr   <= '0;
            tx_count <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                tx_data <= pick_byte;
                grant   <= pick_onehot;
                if (accept_last) begin
                    locked <= 1'b0;
                    rr_ptr <= IDX_W'(wrap_inc(int'(pick_idx), N_REQ));
                end else begin
                    locked <= 1'b1;
                end
            end
            // Unlocked single bytes release the grant once their frame ends.
            if (state == S_WAIT_DONE && !tx_busy && !locked) grant <= '0;
            if (state == S_LAUNCH) tx_count <= tx_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: message-level round-robin model,
// shortened UART busy model, directed and random phases.
module tb_uart_tx_arbiter;

    localparam int N     = 2;
    localparam int CW    = 4;
    localparam int FRAME = 24;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } byte_t;

    typedef struct {
        logic [7:0] data;
        int         src;
        logic       last;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [8*N-1:0]  req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic [7:0]      tx_data;
    logic            tx_start;
    logic            tx_busy;
    logic [N-1:0]    grant;
    logic            locked;
    logic [CW-1:0]   tx_count;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .grant     (grant),
        .locked    (locked),
        .tx_count  (tx_count)
    );

    int    checks = 0;
    int    errors = 0;
    byte_t lq[N][$];
    byte_t bq[N][$];
    ent_t  expq[$];
    int    cyc = 0;
    int    hs_cyc = -100;
    int    last_start = -1;
    int    cnt_model = 0;
    int    ptr_model = 0;
    int    acc[N];
    int    stall_owner = -1;
    int    stall_at = -1;
    int    stall_cnt = 0;
    int    stall_ready = 0;
    int    stall_starts = 0;
    int    busy_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // UART transmitter stand-in: busy from the cycle after tx_start for FRAME cycles.
    initial begin
        logic s;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            s = tx_start;
            @(posedge clk);
            #1;
            if (s) busy_cnt = FRAME;
            else if (busy_cnt > 0) busy_cnt--;
            tx_busy = (busy_cnt != 0);
        end
    end

    // Requester driver plus output monitor.
    initial begin
        logic [N-1:0] fire;
        ent_t e;
        for (int i = 0; i < N; i++) acc[i] = 0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (tx_start === 1'b1) begin
                chk("busy_at_start", {31'd0, tx_busy}, 32'd0);
                chk("start_latency", cyc - hs_cyc, 32'd1);
                if (last_start >= 0) begin
                    checks++;
                    if (cyc - last_start < FRAME + 2) begin
                        errors++;
                        $display("FAIL start_gap actual=%0d required>=%0d", cyc - last_start, FRAME + 2);
                    end
                end
                last_start = cyc;
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start actual_data=%0h required=none", tx_data);
                end else begin
                    e = expq.pop_front();
                    chk("tx_data", {24'd0, tx_data}, {24'd0, e.data});
                    chk("grant", {30'd0, grant}, 32'(1) << e.src);
                    chk("locked", {31'd0, locked}, {31'd0, ~e.last});
                    chk("tx_count", {28'd0, tx_count}, cnt_model);
                end
                cnt_model = (cnt_model + 1) % 16;
            end
            fire = req_valid & req_ready;
            for (int i = 0; i < N; i++)
                if (req_ready[i]) chk("ready_needs_valid", {31'd0, req_valid[i]}, 32'd1);
            if (req_ready != '0) chk("ready_onehot", $countones(req_ready), 32'd1);
            if (fire != '0) hs_cyc = cyc;
            if (stall_cnt > 0) begin
                if (req_ready != '0) stall_ready++;
                if (tx_start) stall_starts++;
            end
            @(posedge clk);
            #1;
            if (stall_cnt > 0) stall_cnt--;
            for (int i = 0; i < N; i++) begin
                if (fire[i] && bq[i].size() > 0) begin
                    void'(bq[i].pop_front());
                    acc[i]++;
                    if (i == stall_owner && acc[i] == stall_at) stall_cnt = 100;
                end
            end
            for (int i = 0; i < N; i++) begin
                if ((stall_cnt > 0 && i == stall_owner) || bq[i].size() == 0) begin
                    req_valid[i] = 1'b0;
                end else begin
                    req_valid[i]        = 1'b1;
                    req_data[i*8 +: 8]  = bq[i][0].data;
                    req_last[i]         = bq[i][0].last;
                end
            end
        end
    end

    task automatic add_byte(input int i, input logic [7:0] d, input logic l);
        byte_t b;
        b.data = d;
        b.last = l;
        lq[i].push_back(b);
    endtask

    // Whole-message round robin: all staged requesters are valid together.
    task automatic model_and_go();
        int    j;
        byte_t b;
        ent_t  e;
        for (int i = 0; i < N; i++) bq[i] = lq[i];
        j = 0;
        while (j >= 0) begin
            j = -1;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (ptr_model + k) % N;
                if (j < 0 && lq[c].size() > 0) j = c;
            end
            if (j >= 0) begin
                b.last = 1'b0;
                while (!b.last && lq[j].size() > 0) begin
                    b = lq[j].pop_front();
                    e.data = b.data;
                    e.src  = j;
                    e.last = b.last;
                    expq.push_back(e);
                end
                ptr_model = (j + 1) % N;
            end
        end
    endtask

    function automatic bit pending();
        bit p;
        p = (expq.size() > 0);
        for (int i = 0; i < N; i++) if (bq[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (pending() && t < 5000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 5000) begin
            errors++;
            $display("FAIL %s_timeout actual_left=%0d required_left=0", name, expq.size());
        end
        repeat (FRAME + 8) @(negedge clk);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_tx_start"}, {31'd0, tx_start}, 32'd0);
        chk({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
        chk({tag, "_grant"}, {30'd0, grant}, 32'd0);
        chk({tag, "_locked"}, {31'd0, locked}, 32'd0);
        chk({tag, "_tx_count"}, {28'd0, tx_count}, 32'd0);
        chk({tag, "_req_ready"}, {30'd0, req_ready}, 32'd0);
    endtask

    initial begin
        int t;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_values("rst");
        rst_n = 1'b1;

        // single byte from requester 0
        add_byte(0, 8'h48, 1'b1);
        model_and_go();
        wait_done("single");
        chk("single_count", {28'd0, tx_count}, 32'd1);
        chk("single_locked", {31'd0, locked}, 32'd0);
        chk("single_grant", {30'd0, grant}, 32'd0);

        // simultaneous single-byte messages
        add_byte(0, 8'h41, 1'b1);
        add_byte(0, 8'h42, 1'b1);
        add_byte(1, 8'h61, 1'b1);
        add_byte(1, 8'h62, 1'b1);
        model_and_go();
        wait_done("alternate");

        // locked string against a competing requester
        add_byte(1, 8'h4f, 1'b0);
        add_byte(1, 8'h4b, 1'b0);
        add_byte(1, 8'h0d, 1'b1);
        add_byte(0, 8'h5a, 1'b1);
        model_and_go();
        wait_done("lock");

        // owner stall mid-message
        stall_ready  = 0;
        stall_starts = 0;
        stall_owner  = 0;
        stall_at     = acc[0] + 1;
        add_byte(0, 8'h31, 1'b0);
        add_byte(0, 8'h32, 1'b0);
        add_byte(0, 8'h33, 1'b1);
        add_byte(1, 8'h77, 1'b1);
        add_byte(1, 8'h78, 1'b1);
        model_and_go();
        wait_done("stall");
        chk("stall_ready_seen", stall_ready, 32'd0);
        chk("stall_starts", stall_starts, 32'd1);
        stall_owner = -1;

        // random message mixes
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < N; i++) begin
                int nm;
                nm = int'($urandom_range(0, 3));
                for (int m = 0; m < nm; m++) begin
                    int len;
                    len = int'($urandom_range(1, 4));
                    for (int b = 0; b < len; b++)
                        add_byte(i, 8'($urandom), (b == len - 1));
                end
            end
            model_and_go();
            wait_done("random");
        end

        // reset while the first frame of a phase is in flight
        add_byte(0, 8'ha1, 1'b0);
        add_byte(0, 8'hb2, 1'b0);
        add_byte(0, 8'hc3, 1'b1);
        add_byte(1, 8'hd4, 1'b1);
        model_and_go();
        t = 0;
        while (expq.size() > 3 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("midframe_first_launch", {31'd0, (t < 200)}, 32'd1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_values("midrst");
        cnt_model = 0;
        rst_n = 1'b1;
        wait_done("midframe");

        // counter wrap: 17 launches from a clean reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cnt_model = 0;
        ptr_model = 0;
        for (int k = 0; k < 17; k++)
            add_byte(int'($urandom_range(0, N - 1)), 8'($urandom), ($urandom_range(0, 2) != 0) || (k == 16));
        for (int i = 0; i < N; i++)
            if (lq[i].size() > 0) lq[i][lq[i].size() - 1].last = 1'b1;
        model_and_go();
        wait_done("wrap");
        chk("wrap_count", {28'd0, tx_count}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
